// File: rtl/top_fifo_out_pkg.sv
// Shared constants and the output word layout for the four-stream TS output block.
package top_fifo_out_pkg;
  localparam int TS_BYTE_W   = 8;
  localparam int NUM_STREAMS = 4;
  localparam int OUT_W       = 10;
  localparam logic [TS_BYTE_W-1:0] SYNC_BYTE = 8'h47;

  typedef struct packed {
    logic                 valid;
    logic                 sync;
    logic [TS_BYTE_W-1:0] data;
  } out_word_t;
endpackage

// File: rtl/async_fifo.sv
// Dual-clock FIFO with Gray-coded pointers and two-flop synchronizers.
// Pops whenever non-empty; writes while full are dropped.
module async_fifo #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rclk,
  input  logic                  rrst_n,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef logic [ADDR_WIDTH:0] ptr_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  ptr_t wbin, wgray, wbin_next, wgray_next;
  ptr_t rbin, rgray, rbin_next;
  ptr_t wq1_rgray, wq2_rgray, rq1_wgray, rq2_wgray;
  logic wfull, wfull_next, wen;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Write domain
  assign wen        = wrst_n && winc && !wfull;
  assign wbin_next  = wbin + ptr_t'(wen);
  assign wgray_next = bin2gray(wbin_next);
  assign wfull_next = (wgray_next == {~wq2_rgray[ADDR_WIDTH:ADDR_WIDTH-1],
                                      wq2_rgray[ADDR_WIDTH-2:0]});

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin      <= '0;
      wgray     <= '0;
      wfull     <= 1'b0;
      wq1_rgray <= '0;
      wq2_rgray <= '0;
    end else begin
      wbin      <= wbin_next;
      wgray     <= wgray_next;
      wfull     <= wfull_next;
      wq1_rgray <= rgray;
      wq2_rgray <= wq1_rgray;
    end
  end

  always_ff @(posedge wclk) begin
    if (wen) mem[wbin[ADDR_WIDTH-1:0]] <= wdata;
  end

  // Read domain
  assign rempty    = (rgray == rq2_wgray);
  assign rbin_next = rbin + ptr_t'(!rempty);
  assign rdata     = mem[rbin[ADDR_WIDTH-1:0]];

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rgray     <= '0;
      rq1_wgray <= '0;
      rq2_wgray <= '0;
    end else begin
      rbin      <= rbin_next;
      rgray     <= bin2gray(rbin_next);
      rq1_wgray <= wgray;
      rq2_wgray <= rq1_wgray;
    end
  end
endmodule

// File: rtl/top_fifo_out.sv
// Four TS streams cross from wclk to rclk through independent FIFOs;
// all drain continuously and mux_ctrl picks which one drives data_out_final.
module top_fifo_out
  import top_fifo_out_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   rclk,
  input  logic                   reset_n,
  input  logic                   wclk,
  input  logic [1:0]             mux_ctrl,
  input  logic [TS_BYTE_W-1:0]   data_s1,
  input  logic [TS_BYTE_W-1:0]   data_s2,
  input  logic [TS_BYTE_W-1:0]   data_s3,
  input  logic [TS_BYTE_W-1:0]   data_s4,
  input  logic [NUM_STREAMS-1:0] valid_in,
  input  logic [NUM_STREAMS-1:0] sync_in,
  output logic [OUT_W-1:0]       data_out_final
);
  logic [1:0]            wrst_sync;
  logic                  wrst_n;
  logic [TS_BYTE_W-1:0]  data_s     [NUM_STREAMS];
  logic [DATA_WIDTH-1:0] fifo_rdata [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] fifo_empty;
  logic [DATA_WIDTH-1:0] rdata_p0   [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] rvalid_p0;
  out_word_t             sel_word;

  always_ff @(posedge wclk) begin
    wrst_sync <= {wrst_sync[0], reset_n};
  end
  assign wrst_n = wrst_sync[1];

  assign data_s[0] = data_s1;
  assign data_s[1] = data_s2;
  assign data_s[2] = data_s3;
  assign data_s[3] = data_s4;

  for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_fifo
    async_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
      .wclk  (wclk),
      .wrst_n(wrst_n),
      .winc  (valid_in[gi]),
      .wdata ({sync_in[gi], data_s[gi]}),
      .rclk  (rclk),
      .rrst_n(reset_n),
      .rdata (fifo_rdata[gi]),
      .rempty(fifo_empty[gi])
    );
  end

  // Stage p0: per-stream read registers, popped every rclk when non-empty
  always_ff @(posedge rclk) begin
    if (!reset_n) begin
      rvalid_p0 <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) rdata_p0[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        rvalid_p0[i] <= !fifo_empty[i];
        if (!fifo_empty[i]) rdata_p0[i] <= fifo_rdata[i];
      end
    end
  end

  always_comb begin
    sel_word       = '0;
    sel_word.valid = rvalid_p0[mux_ctrl];
    sel_word.sync  = rdata_p0[mux_ctrl][TS_BYTE_W];
    sel_word.data  = rdata_p0[mux_ctrl][TS_BYTE_W-1:0];
  end

  // Stage p1: selected channel registered onto the output
  always_ff @(posedge rclk) begin
    if (!reset_n) data_out_final <= '0;
    else          data_out_final <= sel_word;
  end
endmodule

// File: tb/tb_top_fifo_out.sv
// Scoreboard bench for top_fifo_out: directed stimulus pushes expectations, a monitor checks outputs.
`timescale 1ns/1ps
module tb_top_fifo_out;
  import top_fifo_out_pkg::*;

  logic       rclk = 1'b0, wclk = 1'b0, reset_n = 1'b0;
  logic [1:0] mux_ctrl = 2'd0;
  logic [7:0] data_s1 = '0, data_s2 = '0, data_s3 = '0, data_s4 = '0;
  logic [3:0] valid_in = '0, sync_in = '0;
  logic [9:0] data_out_final;

  top_fifo_out dut (
    .rclk(rclk), .reset_n(reset_n), .wclk(wclk), .mux_ctrl(mux_ctrl),
    .data_s1(data_s1), .data_s2(data_s2), .data_s3(data_s3), .data_s4(data_s4),
    .valid_in(valid_in), .sync_in(sync_in), .data_out_final(data_out_final)
  );

  always #18.5 rclk = ~rclk;
  always #4.6  wclk = ~wclk;

  localparam int M_IDLE = 0, M_QUEUE = 1, M_INCR = 2, M_MUX = 3;
  int checks = 0, errors = 0;
  int mode = M_IDLE;
  logic [9:0] exp_q[$];
  logic [9:0] exp_w;
  int rcyc = 0, last_pop_cyc = 0;
  int incr_last = -1, incr_cnt = 0, incr_first = -1;
  int mux_seen[4] = '{0, 0, 0, 0};
  logic [7:0] mux_const[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always @(posedge rclk) rcyc++;

  initial begin : monitor
    logic [1:0] mux_q;
    forever begin
      @(posedge rclk);
      mux_q = mux_ctrl;
      @(negedge rclk);
      if (data_out_final[9] === 1'b1) begin
        case (mode)
          M_QUEUE: begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_word got %h expected none", data_out_final);
            end else begin
              exp_w = exp_q.pop_front();
              last_pop_cyc = rcyc;
              if (data_out_final !== exp_w) begin
                errors++;
                $display("FAIL queue_word got %h expected %h", data_out_final, exp_w);
              end
            end
          end
          M_INCR: begin
            checks++;
            if (int'(data_out_final[7:0]) <= incr_last) begin
              errors++;
              $display("FAIL overflow_order got %0d after %0d", data_out_final[7:0], incr_last);
            end
            if (incr_cnt == 0) incr_first = int'(data_out_final[7:0]);
            incr_last = int'(data_out_final[7:0]);
            incr_cnt++;
          end
          M_MUX: begin
            checks++;
            if (data_out_final[8:0] !== {1'b0, mux_const[mux_q]}) begin
              errors++;
              $display("FAIL mux_follow sel %0d got %h expected %h", mux_q, data_out_final[8:0], {1'b0, mux_const[mux_q]});
            end
            mux_seen[mux_q]++;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic set_byte(input int s, input logic [7:0] b);
    case (s)
      0: data_s1 = b;
      1: data_s2 = b;
      2: data_s3 = b;
      default: data_s4 = b;
    endcase
  endtask

  task automatic wr_word(input int s, input logic [7:0] b, input logic sy);
    @(posedge wclk); #1;
    set_byte(s, b);
    valid_in[s] = 1'b1;
    sync_in[s]  = sy;
    @(posedge wclk); #1;
    valid_in[s] = 1'b0;
    sync_in[s]  = 1'b0;
  endtask

  task automatic wr_burst(input int s, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge wclk); #1;
      set_byte(s, base + 8'(k));
      valid_in[s] = 1'b1;
    end
    @(posedge wclk); #1;
    valid_in[s] = 1'b0;
  endtask

  task automatic rwait(input int n);
    repeat (n) @(posedge rclk);
    #2;
  endtask

  task automatic set_mux(input logic [1:0] m);
    @(posedge rclk); #2;
    mux_ctrl = m;
  endtask

  task automatic drain(input string name, input int max_cyc);
    for (int k = 0; k < max_cyc && exp_q.size() != 0; k++) @(posedge rclk);
    @(negedge rclk); #1;
    check_eq(name, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int wcyc, at_stop;
    // Reset with a write attempted while held
    reset_n = 1'b0;
    repeat (2) @(posedge rclk);
    wr_word(0, 8'hEE, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge rclk);
      check_eq("reset_out", int'(data_out_final), 0);
    end
    @(posedge rclk); #2;
    reset_n = 1'b1;
    mode = M_QUEUE;
    rwait(8);
    @(negedge rclk);
    check_eq("empty_after_reset", int'(data_out_final), 0);

    // Single sync word on stream 1
    exp_q.push_back(10'h347);
    wr_word(0, SYNC_BYTE, 1'b1);
    wcyc = rcyc;
    drain("single_drain", 10);
    check_range("single_latency", last_pop_cyc - wcyc, 2, 5);
    rwait(4);
    @(negedge rclk);
    check_eq("single_valid_drop", int'(data_out_final[9]), 0);

    // Ordering on stream 3
    set_mux(2'd2);
    rwait(2);
    exp_q.push_back(10'h347);
    exp_q.push_back(10'h201);
    exp_q.push_back(10'h202);
    wr_word(2, 8'h47, 1'b1);
    wr_word(2, 8'h01, 1'b0);
    wr_word(2, 8'h02, 1'b0);
    drain("order_drain", 12);
    rwait(4);

    // Overflow on stream 2
    set_mux(2'd1);
    rwait(2);
    incr_last = -1;
    incr_cnt  = 0;
    mode = M_INCR;
    for (int b = 0; b < 100; b++) begin
      @(posedge wclk); #1;
      data_s2 = 8'(b);
      valid_in[1] = 1'b1;
    end
    @(posedge wclk); #1;
    valid_in[1] = 1'b0;
    @(negedge rclk); #1;
    at_stop = incr_cnt;
    rwait(30);
    mode = M_IDLE;
    check_eq("overflow_first", incr_first, 0);
    check_range("overflow_count", incr_cnt, 17, 99);
    check_range("overflow_buffered", incr_cnt - at_stop, 8, 17);

    // Mux switching with all streams active
    @(posedge wclk); #1;
    data_s1 = 8'h11; data_s2 = 8'h22; data_s3 = 8'h33; data_s4 = 8'h44;
    valid_in = 4'hF;
    set_mux(2'd0);
    mode = M_MUX;
    rwait(6);
    for (int m = 0; m < 4; m++) begin
      set_mux(2'(m));
      rwait(6);
    end
    mode = M_IDLE;
    @(posedge wclk); #1;
    valid_in = 4'h0;
    for (int m = 0; m < 4; m++) check_range("mux_seen", mux_seen[m], 3, 1000);
    rwait(30);

    // Reset with data buffered in streams 1 and 4
    set_mux(2'd3);
    wr_burst(3, 8'hA0, 16);
    wr_burst(0, 8'hB0, 4);
    @(posedge rclk); #2;
    reset_n = 1'b0;
    rwait(1);
    wr_word(3, 8'h66, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge rclk);
      check_eq("midrst_out", int'(data_out_final), 0);
    end
    @(posedge rclk); #2;
    reset_n = 1'b1;
    mode = M_QUEUE;
    rwait(8);
    set_mux(2'd0);
    rwait(6);
    set_mux(2'd3);
    rwait(2);
    exp_q.push_back(10'h255);
    wr_word(3, 8'h55, 1'b0);
    drain("post_reset_word", 12);
    rwait(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
